div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clrn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request a division, sampled on the clk edge.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned dividend, sampled with start.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned divisor, sampled with start.
REQ-007 SHALL have port q, output, WIDTH bits: quotient register.
REQ-008 SHALL have port r, output, WIDTH bits: remainder register.
REQ-009 SHALL have port busy, output, 1 bit: iteration in progress.
REQ-010 SHALL have port ready, output, 1 bit: one-cycle pulse, q and r valid.
REQ-011 SHALL have port dbz, output, 1 bit: divide-by-zero flag, present only under DIV_BY_ZERO_EN.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE, with a counter of clog2(WIDTH)+1 bits.
REQ-013 SHALL accept start only in IDLE or DONE; start in RUN is ignored with no state change.
REQ-014 On an accepted start (edge E0): q<=dividend (load select), r<=0, latched divisor<=divisor, count<=0, state<=RUN.
REQ-015 Each RUN edge: shift {r,q} left 1; trial = shifted r minus divisor at WIDTH+1 bits.
REQ-016 If trial is non-negative: r<=trial and q[0]<=1; otherwise r keeps the shifted value and q[0]<=0.
REQ-017 After the WIDTH-th RUN step (edge E0+WIDTH), the state SHALL go to DONE.
REQ-018 From DONE, the next edge SHALL go to IDLE unless start is accepted.
REQ-019 busy=1 exactly in RUN, from after E0 through edge E0+WIDTH.
REQ-020 ready=1 exactly in DONE: one cycle after edge E0+WIDTH; latency is WIDTH+1 edges from start.
REQ-021 q and r SHALL hold their final values after DONE until the next accepted start.
REQ-022 All arithmetic is unsigned; no result overflow is possible; the carry/borrow bit is internal only.

Reset
REQ-023 clrn=0 SHALL immediately force state=IDLE, q=0, r=0, count=0, busy=0, ready=0 and dbz=0, regardless of clk.
REQ-024 Reset mid-RUN SHALL abort the division; no ready pulse follows; the next start behaves as from power-up.

Configuration
REQ-025 Macro DIV_BY_ZERO_EN defined: accepted start with divisor==0 goes directly to DONE at the next edge (ready one edge after start).
- Outputs on that path: q=all ones, r=dividend, dbz=1.
- dbz holds until the next accepted start and is cleared by any accepted start with divisor!=0.
REQ-026 DIV_BY_ZERO_EN undefined: no dbz port; divisor==0 runs the normal WIDTH iterations, naturally yielding q=all ones, r=dividend.

Structure
REQ-027 Shared package div_pkg SHALL hold the state enum typedef (IDLE/RUN/DONE) and the default width constant DIV_WIDTH=32.
REQ-028 Sub-module div_step SHALL be combinational: inputs r, q, divisor; outputs next r, next q; it implements REQ-015 and REQ-016.
REQ-029 The q load/update selection SHALL be a 2:1 mux on start acceptance: dividend on load, div_step output otherwise.

Verification
REQ-030 100/7, WIDTH=32 -> ready exactly 33 edges after start; q=14, r=2; busy high for 32 cycles.
REQ-031 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
REQ-032 Two sub-cases:
- 5/10 -> q=0, r=5.
- 0x80000000/0x80000000 -> q=1, r=0.
REQ-033 Start 1000/3, then re-pulse start with 9/9 at edge E0+10 -> second request ignored; result q=333, r=1; single ready pulse.
REQ-034 Two sub-cases:
- clrn low at edge E0+15 of 1000/3 -> all outputs 0 immediately, no ready pulse.
- Subsequent 42/5 -> q=8, r=2.
REQ-035 Divisor 0, dividend 0x1234, two builds:
- DIV_BY_ZERO_EN defined: ready one edge after start, q=0xFFFFFFFF, r=0x1234, dbz=1.
- DIV_BY_ZERO_EN undefined: same q and r after 33 edges.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r,q} left, trial-subtract the
// divisor from the shifted remainder, keep the difference if it did not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_r,
  output logic [WIDTH-1:0] o_q
);

  // Shifted remainder keeps its carried-out MSB so divisors above 2^(WIDTH-1) work.
  logic [WIDTH:0] w_shift_r;
  logic [WIDTH:0] w_trial;

  // Trial subtraction and restore/keep selection.
  always_comb begin
    w_shift_r = {i_r, i_q[WIDTH-1]};
    w_trial   = w_shift_r - {1'b0, i_divisor};
    if (!w_trial[WIDTH]) begin
      o_r = w_trial[WIDTH-1:0];
      o_q = {i_q[WIDTH-2:0], 1'b1};
    end else begin
      o_r = w_shift_r[WIDTH-1:0];
      o_q = {i_q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider, one quotient bit per clock (WIDTH iterations).
// Optional feature: define DIV_BY_ZERO_EN to add the dbz port and a
// single-edge divide-by-zero shortcut.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready
`ifdef DIV_BY_ZERO_EN
  ,
  output logic             dbz
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_e     r_state;
  div_state_e     w_state_nxt;
  logic [CW-1:0]  r_count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] w_step_q;
  logic [WIDTH-1:0] w_step_r;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_zero;
`ifdef DIV_BY_ZERO_EN
  logic             r_dbz;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r       (r_r),
    .i_q       (r_q),
    .i_divisor (r_div),
    .o_r       (w_step_r),
    .o_q       (w_step_q)
  );

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_count == CW'(WIDTH - 1));
  assign w_q_nxt  = w_accept ? dividend : w_step_q;
`ifdef DIV_BY_ZERO_EN
  assign w_zero   = (divisor == '0);
`else
  assign w_zero   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: start is only honoured outside RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      default: begin
        if (start)      w_state_nxt = w_zero ? DONE : RUN;
        else            w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: load on accepted start, iterate in RUN, otherwise hold.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_q     <= '0;
      r_r     <= '0;
      r_div   <= '0;
      r_count <= '0;
`ifdef DIV_BY_ZERO_EN
      r_dbz   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_q     <= w_q_nxt;
      r_r     <= '0;
      r_div   <= divisor;
      r_count <= '0;
`ifdef DIV_BY_ZERO_EN
      r_dbz   <= w_zero;
      if (w_zero) begin
        r_q <= '1;
        r_r <= dividend;
      end
`endif
    end else if (r_state == RUN) begin
      r_q     <= w_q_nxt;
      r_r     <= w_step_r;
      r_count <= r_count + CW'(1);
    end
  end

  assign q     = r_q;
  assign r     = r_r;
  assign busy  = (r_state == RUN);
  assign ready = (r_state == DONE);
`ifdef DIV_BY_ZERO_EN
  assign dbz   = r_dbz;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases plus random operands
// against an arithmetic reference. Honours DIV_BY_ZERO_EN when defined.
module tb_div_seq;
  import div_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         clrn = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         ready;
`ifdef DIV_BY_ZERO_EN
  logic         dbz;
`endif

  int checks = 0;
  int failures = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .ready    (ready)
`ifdef DIV_BY_ZERO_EN
    ,
    .dbz      (dbz)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned division; zero divisor yields all ones / dividend.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic [W-1:0] er);
    if (b == '0) begin
      eq = '1;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  // Issue one division; optionally re-pulse start (9/9) at edge E0+repulse.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag, input int repulse);
    logic [W-1:0] eq, er;
    int n, busy_n, exp_lat, exp_busy;
    ref_div(a, b, eq, er);
    exp_lat  = W + 1;
    exp_busy = W;
`ifdef DIV_BY_ZERO_EN
    if (b == '0) begin
      exp_lat  = 1;
      exp_busy = 0;
    end
`endif
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n      = 1;
    busy_n = busy ? 1 : 0;
    while (!ready && n < 200) begin
      if (repulse != 0 && n == repulse) begin
        start    = 1'b1;
        dividend = 9;
        divisor  = 9;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (busy) busy_n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_q"}, 64'(q), 64'(eq));
    chk({tag, "_r"}, 64'(r), 64'(er));
`ifdef DIV_BY_ZERO_EN
    chk({tag, "_dbz"}, 64'(dbz), 64'(b == '0));
`endif
    @(posedge clk);
    #1;
    chk({tag, "_ready_pulse_end"}, 64'(ready), 64'd0);
    chk({tag, "_q_hold"}, 64'(q), 64'(eq));
    chk({tag, "_r_hold"}, 64'(r), 64'(er));
`ifdef DIV_BY_ZERO_EN
    chk({tag, "_dbz_hold"}, 64'(dbz), 64'(b == '0));
`endif
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int sel;

    // Power-up reset state.
    #2;
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
`ifdef DIV_BY_ZERO_EN
    chk("rst_dbz", 64'(dbz), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;

    // Directed cases.
    run_div(32'd100, 32'd7, "d100_7", 0);
    run_div(32'hFFFF_FFFF, 32'd1, "dmax_1", 0);
    run_div(32'd5, 32'd10, "d5_10", 0);
    run_div(32'h8000_0000, 32'h8000_0000, "dmsb_msb", 0);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, "dmax_big", 0);
    run_div(32'd1000, 32'd3, "d1000_3_repulse", 10);
    run_div(32'h1234, 32'd0, "d1234_0", 0);
    run_div(32'd77, 32'd5, "after_zero", 0);

    // Reset in the middle of a run.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("midrun_busy", 64'(busy), 64'd1);
    #2;
    clrn = 1'b0;
    #1;
    chk("abort_q", 64'(q), 64'd0);
    chk("abort_r", 64'(r), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(ready), 64'd0);
`ifdef DIV_BY_ZERO_EN
    chk("abort_dbz", 64'(dbz), 64'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_ready", 64'(ready), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end
    run_div(32'd42, 32'd5, "d42_5_after_abort", 0);

    // Random operands with a spread of divisor magnitudes.
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       rb = $urandom;
        1:       rb = $urandom >> $urandom_range(1, 31);
        2:       rb = $urandom_range(1, 16);
        3:       rb = '0;
        default: rb = $urandom | 32'h8000_0000;
      endcase
      run_div(ra, rb, $sformatf("rand%0d", i), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
